// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer
//   Physical-interface stage for a 16x2 character LCD driven in 4-bit mode.
//   After reset it runs the power-on nibble initialisation (0x3, 0x3, 0x3, 0x2)
//   on its own. It then accepts bytes from the upstream sequencer over a
//   valid/ready handshake and writes each one as two E-strobed nibbles,
//   high nibble first. The inter-nibble and post-byte waits are inserted here,
//   so upstream logic never has to count LCD timing.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cmd_valid  upstream byte available
//   cmd_ready  block accepts a byte this cycle (high only in IDLE)
//   cmd_rs     0 = instruction, 1 = data (DDRAM character)
//   cmd_data   byte to write
//   init_done  power-on init complete; stays set until reset
//   LCD_E      LCD enable strobe
//   LCD_RS     LCD register select
//   LCD_RW     LCD read/write, tied to write (0)
//   SF_D11..8  LCD data nibble (bit 7/3 .. bit 4/0)
module lcd_nibble_writer #(
  parameter int POWERON_WAIT = 750000,
  parameter int INIT_WAIT1   = 205000,
  parameter int INIT_WAIT2   = 5000,
  parameter int INIT_WAIT3   = 2000,
  parameter int E_HIGH       = 12,
  parameter int NIB_GAP      = 50,
  parameter int BYTE_GAP     = 2000,
  parameter int CLEAR_GAP    = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       SF_D11,
  output logic       SF_D10,
  output logic       SF_D9,
  output logic       SF_D8
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_WAIT = max2(max2(max2(POWERON_WAIT, INIT_WAIT1),
                                      max2(INIT_WAIT2, INIT_WAIT3)),
                                 max2(max2(E_HIGH, NIB_GAP),
                                      max2(BYTE_GAP, CLEAR_GAP)));
  localparam int CW_NEED  = $clog2(MAX_WAIT + 1);
  localparam int CW       = (CW_NEED < 20) ? 20 : CW_NEED;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_E,
    INIT_GAP,
    IDLE,
    HI_SETUP,
    HI_E,
    NIB_WAIT,
    LO_SETUP,
    LO_E,
    BYTE_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;
  logic          cnt_done;
  logic [1:0]    init_idx;
  logic [1:0]    init_idx_nxt;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic [3:0]    nib_out;
  logic          transfer;
  logic          is_clear;

  assign transfer = cmd_valid && cmd_ready;

  // Clear display (0x01) and return home (0x02) need the long post-byte wait.
  assign is_clear = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));

  // Last count value of the state currently being timed; the counter starts
  // at 0 on every state entry, so a state lasts (target) cycles.
  always_comb begin
    cnt_last = '0;
    case (state)
      PWR_WAIT:          cnt_last = CW'(POWERON_WAIT - 1);
      INIT_E, HI_E, LO_E: cnt_last = CW'(E_HIGH - 1);
      INIT_GAP: begin
        case (init_idx)
          2'd0:    cnt_last = CW'(INIT_WAIT1 - 1);
          2'd1:    cnt_last = CW'(INIT_WAIT2 - 1);
          default: cnt_last = CW'(INIT_WAIT3 - 1);
        endcase
      end
      NIB_WAIT:          cnt_last = CW'(NIB_GAP - 1);
      BYTE_WAIT:         cnt_last = is_clear ? CW'(CLEAR_GAP - 1) : CW'(BYTE_GAP - 1);
      default:           cnt_last = '0;
    endcase
  end

  assign cnt_done = (cnt == cnt_last);

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      PWR_WAIT:   if (cnt_done) state_nxt = INIT_SETUP;
      INIT_SETUP: state_nxt = INIT_E;
      INIT_E:     if (cnt_done) state_nxt = INIT_GAP;
      INIT_GAP: begin
        if (cnt_done) begin
          if (init_idx == 2'd3) begin
            state_nxt = IDLE;
          end else begin
            init_idx_nxt = init_idx + 2'd1;
            state_nxt    = INIT_SETUP;
          end
        end
      end
      IDLE:       if (transfer) state_nxt = HI_SETUP;
      HI_SETUP:   state_nxt = HI_E;
      HI_E:       if (cnt_done) state_nxt = NIB_WAIT;
      NIB_WAIT:   if (cnt_done) state_nxt = LO_SETUP;
      LO_SETUP:   state_nxt = LO_E;
      LO_E:       if (cnt_done) state_nxt = BYTE_WAIT;
      BYTE_WAIT:  if (cnt_done) state_nxt = IDLE;
      default:    state_nxt = PWR_WAIT;
    endcase
  end

  // Outputs are registered from the next state, so each pin reflects the
  // state it belongs to in the same cycle. Data/RS only change on entry to a
  // setup state, when E is already low, and then hold through the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
      cmd_ready <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      nib_out   <= 4'h0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
      if ((state_nxt != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      cmd_ready <= (state_nxt == IDLE);
      if ((state == INIT_GAP) && (state_nxt == IDLE)) begin
        init_done <= 1'b1;
      end
      LCD_E <= (state_nxt == INIT_E) || (state_nxt == HI_E) || (state_nxt == LO_E);
      case (state_nxt)
        INIT_SETUP: begin
          nib_out <= (init_idx_nxt == 2'd3) ? 4'h2 : 4'h3;
          LCD_RS  <= 1'b0;
        end
        HI_SETUP: begin
          nib_out <= cmd_data[7:4];
          LCD_RS  <= cmd_rs;
        end
        LO_SETUP: begin
          nib_out <= byte_q[3:0];
          LCD_RS  <= rs_q;
        end
        default: ;
      endcase
    end
  end

  // Byte latch: captured on the accepting cycle, later input changes ignored.
  always_ff @(posedge clk) begin
    if (transfer) begin
      byte_q <= cmd_data;
      rs_q   <= cmd_rs;
    end
  end

  assign LCD_RW = 1'b0;
  assign SF_D11 = nib_out[3];
  assign SF_D10 = nib_out[2];
  assign SF_D9  = nib_out[1];
  assign SF_D8  = nib_out[0];

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Physical-interface stage for the 16x2 character LCD in 4-bit mode (SF_D11..SF_D8, LCD_E, LCD_RS, LCD_RW).
- Runs the power-on nibble initialisation itself.
- Then accepts byte-wide commands and characters from the upstream display sequencer over a valid/ready handshake.
- Sends each byte as two E-strobed nibbles with the required inter-nibble and post-byte waits, so upstream logic never counts LCD timing.

Parameters:
- POWERON_WAIT, 750000, cycles from reset release to the first init nibble (15 ms at 50 MHz).
- INIT_WAIT1, 205000, wait after init nibble 1 (4.1 ms).
- INIT_WAIT2, 5000, wait after init nibble 2 (100 us).
- INIT_WAIT3, 2000, wait after init nibbles 3 and 4 (40 us).
- E_HIGH, 12, LCD_E high width in cycles (240 ns).
- NIB_GAP, 50, E-low cycles between the high and low nibble (1 us).
- BYTE_GAP, 2000, E-low cycles after the low nibble of a normal byte (40 us).
- CLEAR_GAP, 82000, E-low cycles after a clear/home command (1.64 ms).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  upstream byte available
- cmd_ready  out  1  block can accept a byte this cycle
- cmd_rs  in  1  0 = instruction, 1 = data (DDRAM character)
- cmd_data  in  8  byte to write
- init_done  out  1  power-on nibble init complete, sticky until reset
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/write, always 0
- SF_D11  out  1  LCD data bit 7/3
- SF_D10  out  1  LCD data bit 6/2
- SF_D9  out  1  LCD data bit 5/1
- SF_D8  out  1  LCD data bit 4/0

Behaviour:
- Interface: one clock, synchronous active-low reset `rst_n` sampled on the rising edge of `clk`; all outputs registered.
- Reset values:
  - LCD_E = 0, LCD_RS = 0, LCD_RW = 0, SF_D11..8 = 0.
  - cmd_ready = 0, init_done = 0.
  - FSM = PWR_WAIT, delay counter = 0.
- Delay counter: 20 bits minimum, wide enough for the largest parameter; it counts up and compares to the active target.
- Nibble strobe (shared by init and byte writes):
  - 1 setup cycle with data/RS driven and E = 0.
  - E_HIGH cycles with E = 1.
  - E returns to 0; data and RS hold until the next nibble's setup cycle.
- FSM states: PWR_WAIT, INIT_SETUP, INIT_E, INIT_GAP, IDLE, HI_SETUP, HI_E, NIB_WAIT, LO_SETUP, LO_E, BYTE_WAIT.
- Init sequence:
  - PWR_WAIT lasts POWERON_WAIT cycles.
  - Then four strobes with RS = 0: nibble 0x3, 0x3, 0x3, 0x2.
  - Waits after each strobe (counted from the E falling edge): INIT_WAIT1, INIT_WAIT2, INIT_WAIT3, INIT_WAIT3.
  - A 2-bit init index selects the nibble and wait.
  - After the fourth wait: init_done = 1, enter IDLE.
- cmd_ready = 1 only in IDLE. Transfer occurs on a cycle with cmd_valid && cmd_ready.
- On transfer, in the same cycle: latch cmd_rs and cmd_data, drop cmd_ready, go to HI_SETUP. Later changes on the cmd_* inputs have no effect.
- Byte write:
  - HI_SETUP drives cmd_data[7:4] and RS.
  - HI_E, then NIB_WAIT for NIB_GAP cycles.
  - LO_SETUP drives cmd_data[3:0].
  - LO_E, then BYTE_WAIT.
- BYTE_WAIT length: CLEAR_GAP if latched rs = 0 and data is 0x01 or 0x02; otherwise BYTE_GAP. Then return to IDLE, where cmd_ready = 1 the next cycle.
- Byte timing: transfer at cycle T → LCD_E high during T+2..T+1+E_HIGH and T+3+E_HIGH+NIB_GAP..T+2+2·E_HIGH+NIB_GAP.
- cmd_valid is ignored while not in IDLE, including during init. There is no buffering and no drop signalling; upstream holds cmd_valid until cmd_ready.
- Reset asserted mid-strobe or mid-wait: at the next edge LCD_E = 0 and all reset values apply; init restarts from PWR_WAIT.
- LCD_E is never high for more than E_HIGH consecutive cycles, and data/RS never change while LCD_E = 1.

Test Plan:
Sim parameters: POWERON_WAIT=20, INIT_WAIT1=15, INIT_WAIT2=10, INIT_WAIT3=8, E_HIGH=3, NIB_GAP=4, BYTE_GAP=6, CLEAR_GAP=12.
- Reset release, no commands → E pulses of 3 cycles carrying nibbles 3,3,3,2 with RS = 0; gaps from E fall of 15, 10, 8, 8; init_done and cmd_ready = 1 exactly after the last gap; RW = 0 throughout.
- After init, send rs=1, data=0x32 ('2') → pins show 0x3 then 0x2 with RS = 1; E high at T+2..T+4 and T+10..T+12; cmd_ready returns 6 cycles after the second E fall.
- Send rs=0, data=0x01 → BYTE_WAIT lasts 12 cycles. Send rs=0, data=0x80 → 6 cycles. Send rs=1, data=0x01 → 6 cycles (data, not clear).
- Hold cmd_valid high with changing cmd_data during the init and busy phases → nothing accepted before init_done; only the value present on the first cmd_ready cycle is written; back-to-back bytes are spaced by the full BYTE_GAP.
- Assert rst_n = 0 while LCD_E is high during the low nibble → LCD_E = 0, cmd_ready = 0, init_done = 0 at the next edge; after release the full init sequence repeats.
- Assertion check for the whole run: data/RS stable while E = 1, and E-high run length is always 3 cycles.
